// File: rtl/sram_pkg.sv
// Shared constants and helpers for the 1RW/1R SRAM wrapper.
package sram_pkg;

    localparam int unsigned WRITE_MODE_READ_FIRST  = 0;
    localparam int unsigned WRITE_MODE_WRITE_FIRST = 1;

    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 2;

    localparam int unsigned COLL_CNT_W = 8;

    function automatic int unsigned num_wmasks(input int unsigned data_width,
                                               input int unsigned write_size);
        return data_width / write_size;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Storage core: one lane-masked synchronous write port, two combinational read ports, no reset.
module sram_array
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned WRITE_SIZE = 8
) (
    input  logic                                         clk,
    input  logic                                         we,
    input  logic [ADDR_WIDTH-1:0]                        waddr,
    input  logic [DATA_WIDTH-1:0]                        wdata,
    input  logic [num_wmasks(DATA_WIDTH, WRITE_SIZE)-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]                        raddr0,
    output logic [DATA_WIDTH-1:0]                        rdata0,
    input  logic [ADDR_WIDTH-1:0]                        raddr1,
    output logic [DATA_WIDTH-1:0]                        rdata1
);

    localparam int unsigned NUM_WMASKS = num_wmasks(DATA_WIDTH, WRITE_SIZE);
    localparam int unsigned DEPTH      = 32'(1) << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
                if (wmask[i]) begin
                    mem_q[waddr][i*WRITE_SIZE +: WRITE_SIZE] <= wdata[i*WRITE_SIZE +: WRITE_SIZE];
                end
            end
        end
    end

    // Reads see the pre-edge contents, giving read-first behaviour at a same-edge write.
    assign rdata0 = mem_q[raddr0];
    assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/sram_1rw1r_param.sv
// 1RW + 1R SRAM wrapper: read pipeline (latency 1 or 2), optional write-first bypass on port 1,
// and an optional same-address collision monitor enabled by macro SRAM_COLLISION_CHECK_EN.
module sram_1rw1r_param
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned WRITE_SIZE   = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WRITE_FIRST  = 0
) (
    input  logic                                         clk,
    input  logic                                         rstb,
    input  logic                                         csb0,
    input  logic                                         web0,
    input  logic [ADDR_WIDTH-1:0]                        addr0,
    input  logic [DATA_WIDTH-1:0]                        din0,
    input  logic [num_wmasks(DATA_WIDTH, WRITE_SIZE)-1:0] wmask0,
    output logic [DATA_WIDTH-1:0]                        dout0,
    output logic                                         dout0_vld,
    input  logic                                         csb1,
    input  logic [ADDR_WIDTH-1:0]                        addr1,
    output logic [DATA_WIDTH-1:0]                        dout1,
    output logic                                         dout1_vld
`ifdef SRAM_COLLISION_CHECK_EN
    ,
    output logic                                         collision,
    output logic [COLL_CNT_W-1:0]                        collision_cnt
`endif
);

    localparam int unsigned NUM_WMASKS = num_wmasks(DATA_WIDTH, WRITE_SIZE);

    if ((DATA_WIDTH % WRITE_SIZE) != 0) begin : g_bad_write_size
        $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of WRITE_SIZE");
    end
    if ((READ_LATENCY < READ_LATENCY_MIN) || (READ_LATENCY > READ_LATENCY_MAX)) begin : g_bad_latency
        $error("sram_1rw1r_param: READ_LATENCY must be 1 or 2");
    end

    logic                  we0_c;
    logic                  rd0_c;
    logic                  rd1_c;
    logic                  hit_c;
    logic [DATA_WIDTH-1:0] bit_mask_c;
    logic [DATA_WIDTH-1:0] rd1_word_c;
    logic [DATA_WIDTH-1:0] arr_rdata0;
    logic [DATA_WIDTH-1:0] arr_rdata1;

    logic                  s1_vld0_q, s1_vld0_d;
    logic                  s1_vld1_q, s1_vld1_d;
    logic [DATA_WIDTH-1:0] s1_data0_q, s1_data0_d;
    logic [DATA_WIDTH-1:0] s1_data1_q, s1_data1_d;

    sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WRITE_SIZE (WRITE_SIZE)
    ) u_array (
        .clk    (clk),
        .we     (we0_c),
        .waddr  (addr0),
        .wdata  (din0),
        .wmask  (wmask0),
        .raddr0 (addr0),
        .rdata0 (arr_rdata0),
        .raddr1 (addr1),
        .rdata1 (arr_rdata1)
    );

    // Request decode, write-first bypass and first pipeline stage; data holds when idle.
    always_comb begin
        we0_c      = rstb & ~csb0 & ~web0;
        rd0_c      = rstb & ~csb0 & web0;
        rd1_c      = rstb & ~csb1;
        hit_c      = we0_c & rd1_c & (addr0 == addr1);
        bit_mask_c = '0;
        for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
            bit_mask_c[i*WRITE_SIZE +: WRITE_SIZE] = {WRITE_SIZE{wmask0[i]}};
        end
        rd1_word_c = arr_rdata1;
        if ((WRITE_FIRST != WRITE_MODE_READ_FIRST) && hit_c) begin
            rd1_word_c = (arr_rdata1 & ~bit_mask_c) | (din0 & bit_mask_c);
        end
        s1_vld0_d  = rd0_c;
        s1_vld1_d  = rd1_c;
        s1_data0_d = rd0_c ? arr_rdata0 : s1_data0_q;
        s1_data1_d = rd1_c ? rd1_word_c : s1_data1_q;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_vld0_q  <= 1'b0;
            s1_vld1_q  <= 1'b0;
            s1_data0_q <= '0;
            s1_data1_q <= '0;
        end else begin
            s1_vld0_q  <= s1_vld0_d;
            s1_vld1_q  <= s1_vld1_d;
            s1_data0_q <= s1_data0_d;
            s1_data1_q <= s1_data1_d;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_vld0_q, s2_vld0_d;
        logic                  s2_vld1_q, s2_vld1_d;
        logic [DATA_WIDTH-1:0] s2_data0_q, s2_data0_d;
        logic [DATA_WIDTH-1:0] s2_data1_q, s2_data1_d;

        // Extra output register; captures only completing reads so the output holds otherwise.
        always_comb begin
            s2_vld0_d  = s1_vld0_q;
            s2_vld1_d  = s1_vld1_q;
            s2_data0_d = s1_vld0_q ? s1_data0_q : s2_data0_q;
            s2_data1_d = s1_vld1_q ? s1_data1_q : s2_data1_q;
        end

        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                s2_vld0_q  <= 1'b0;
                s2_vld1_q  <= 1'b0;
                s2_data0_q <= '0;
                s2_data1_q <= '0;
            end else begin
                s2_vld0_q  <= s2_vld0_d;
                s2_vld1_q  <= s2_vld1_d;
                s2_data0_q <= s2_data0_d;
                s2_data1_q <= s2_data1_d;
            end
        end

        assign dout0     = s2_data0_q;
        assign dout0_vld = s2_vld0_q;
        assign dout1     = s2_data1_q;
        assign dout1_vld = s2_vld1_q;
    end else begin : g_lat1
        assign dout0     = s1_data0_q;
        assign dout0_vld = s1_vld0_q;
        assign dout1     = s1_data1_q;
        assign dout1_vld = s1_vld1_q;
    end

`ifdef SRAM_COLLISION_CHECK_EN
    logic                  coll_q, coll_d;
    logic [COLL_CNT_W-1:0] coll_cnt_q, coll_cnt_d;

    // Same-address write/read monitor with a saturating event counter.
    always_comb begin
        coll_d     = hit_c;
        coll_cnt_d = coll_cnt_q;
        if (hit_c && (coll_cnt_q != {COLL_CNT_W{1'b1}})) begin
            coll_cnt_d = coll_cnt_q + COLL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            coll_q     <= coll_d;
            coll_cnt_q <= coll_cnt_d;
        end
    end

    assign collision     = coll_q;
    assign collision_cnt = coll_cnt_q;
`endif

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: drives a latency-1/read-first and a latency-2/write-first instance
// with identical stimulus and checks both against a schedule-based memory model.
module tb_sram_1rw1r_param;

    logic        clk;
    logic        rstb;
    logic        csb0;
    logic        web0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic [3:0]  wmask0;
    logic        csb1;
    logic [7:0]  addr1;

    logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
    logic        vld0_a, vld1_a, vld0_b, vld1_b;
`ifdef SRAM_COLLISION_CHECK_EN
    logic        coll_a, coll_b;
    logic [7:0]  cnt_a, cnt_b;
`endif

    int checks = 0;
    int errors = 0;

    sram_1rw1r_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .WRITE_SIZE(8), .READ_LATENCY(1), .WRITE_FIRST(0)
    ) dut_a (
        .clk(clk), .rstb(rstb), .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0),
        .wmask0(wmask0), .dout0(dout0_a), .dout0_vld(vld0_a), .csb1(csb1), .addr1(addr1),
        .dout1(dout1_a), .dout1_vld(vld1_a)
`ifdef SRAM_COLLISION_CHECK_EN
        , .collision(coll_a), .collision_cnt(cnt_a)
`endif
    );

    sram_1rw1r_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .WRITE_SIZE(8), .READ_LATENCY(2), .WRITE_FIRST(1)
    ) dut_b (
        .clk(clk), .rstb(rstb), .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0),
        .wmask0(wmask0), .dout0(dout0_b), .dout0_vld(vld0_b), .csb1(csb1), .addr1(addr1),
        .dout1(dout1_b), .dout1_vld(vld1_b)
`ifdef SRAM_COLLISION_CHECK_EN
        , .collision(coll_b), .collision_cnt(cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word array plus a per-edge delivery schedule for each instance/port.
    logic [31:0] m_mem [256];
    logic        slot_vld [2][2][4];
    logic [31:0] slot_dat [2][2][4];
    logic        exp_vld  [2][2];
    logic [31:0] exp_dout [2][2];
    logic        exp_coll;
    int          exp_cnt;
    int          n_edge = 0;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int l = 0; l < 4; l++) begin
            if (m[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                exp_vld[d][p]  = 1'b0;
                exp_dout[d][p] = 32'h0;
                for (int s = 0; s < 4; s++) begin
                    slot_vld[d][p][s] = 1'b0;
                    slot_dat[d][p][s] = 32'h0;
                end
            end
        end
        exp_coll = 1'b0;
        exp_cnt  = 0;
    endtask

    task automatic model_edge();
        logic        w, r0, r1, same;
        logic [31:0] new_w;
        int          lat, due;
        if (!rstb) begin
            model_reset();
            return;
        end
        w     = !csb0 && !web0;
        r0    = !csb0 && web0;
        r1    = !csb1;
        same  = (addr0 == addr1);
        new_w = merge(m_mem[addr0], din0, wmask0);
        for (int d = 0; d < 2; d++) begin
            lat = d + 1;
            due = (n_edge + lat - 1) % 4;
            if (r0) begin
                slot_vld[d][0][due] = 1'b1;
                slot_dat[d][0][due] = m_mem[addr0];
            end
            if (r1) begin
                slot_vld[d][1][due] = 1'b1;
                slot_dat[d][1][due] = (d == 1 && w && same) ? new_w : m_mem[addr1];
            end
            for (int p = 0; p < 2; p++) begin
                exp_vld[d][p] = slot_vld[d][p][n_edge % 4];
                if (exp_vld[d][p]) exp_dout[d][p] = slot_dat[d][p][n_edge % 4];
                slot_vld[d][p][n_edge % 4] = 1'b0;
            end
        end
        exp_coll = w && r1 && same;
        if (exp_coll && exp_cnt < 255) exp_cnt++;
        if (w) m_mem[addr0] = new_w;
        n_edge++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("a_vld0",  32'(vld0_a),  32'(exp_vld[0][0]));
        chk("a_dout0", dout0_a,      exp_dout[0][0]);
        chk("a_vld1",  32'(vld1_a),  32'(exp_vld[0][1]));
        chk("a_dout1", dout1_a,      exp_dout[0][1]);
        chk("b_vld0",  32'(vld0_b),  32'(exp_vld[1][0]));
        chk("b_dout0", dout0_b,      exp_dout[1][0]);
        chk("b_vld1",  32'(vld1_b),  32'(exp_vld[1][1]));
        chk("b_dout1", dout1_b,      exp_dout[1][1]);
`ifdef SRAM_COLLISION_CHECK_EN
        chk("a_coll",  32'(coll_a),  32'(exp_coll));
        chk("a_cnt",   32'(cnt_a),   32'(exp_cnt));
        chk("b_coll",  32'(coll_b),  32'(exp_coll));
        chk("b_cnt",   32'(cnt_b),   32'(exp_cnt));
`endif
    endtask

    // One clock: model the edge, check just after it, return at the next falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    endtask

    task automatic wr0(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    endtask

    initial begin
        int vld_count;
        rstb = 1'b0; csb0 = 1'b1; web0 = 1'b1; addr0 = 8'h0; din0 = 32'h0; wmask0 = 4'h0;
        csb1 = 1'b1; addr1 = 8'h0;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all();
        chk("reset_dout1_b", dout1_b, 32'h0);
        @(negedge clk);
        rstb = 1'b1;

        // Fill every word so nothing read later is undefined.
        for (int i = 0; i < 256; i++) begin
            wr0(8'(i), $urandom, 4'hF);
            m_mem[i] = 32'h0;
            step();
        end
        idle();

        // Full write then port-1 readback.
        wr0(8'h05, 32'hDEADBEEF, 4'b1111);
        step();
        idle(); csb1 = 1'b0; addr1 = 8'h05;
        step();
        chk("full_a_dout1", dout1_a, 32'hDEADBEEF);
        chk("full_a_vld1",  32'(vld1_a), 32'd1);
        chk("full_b_vld1_early", 32'(vld1_b), 32'd0);
        idle();
        step();
        chk("full_b_dout1", dout1_b, 32'hDEADBEEF);
        chk("full_b_vld1",  32'(vld1_b), 32'd1);
        chk("full_a_vld1_once", 32'(vld1_a), 32'd0);

        // Partial write lanes 0 and 2.
        wr0(8'h05, 32'h11223344, 4'b0101);
        step();
        idle(); csb1 = 1'b0; addr1 = 8'h05;
        step();
        chk("partial_a", dout1_a, 32'hDE22BE44);
        idle();
        step();
        chk("partial_b", dout1_b, 32'hDE22BE44);

        // Same-edge write/read collision.
        wr0(8'h05, 32'hAAAAAAAA, 4'hF);
        step();
        wr0(8'h05, 32'h55555555, 4'hF); csb1 = 1'b0; addr1 = 8'h05;
        step();
        chk("coll_a_old", dout1_a, 32'hAAAAAAAA);
`ifdef SRAM_COLLISION_CHECK_EN
        chk("coll_pulse", 32'(coll_a), 32'd1);
        chk("coll_cnt1",  32'(cnt_a),  32'd1);
`endif
        idle();
        step();
        chk("coll_b_new", dout1_b, 32'h55555555);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h05;
        step();
        chk("after_wr_a_dout0", dout0_a, 32'h55555555);
        idle();
        step();
        chk("after_wr_b_dout0", dout0_b, 32'h55555555);

        // Reset while a latency-2 read is in flight; requests during reset are ignored.
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h05;
        step();
        idle();
        rstb = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("midrst_b_dout0", dout0_b, 32'h0);
        chk("midrst_b_vld0",  32'(vld0_b), 32'd0);
        wr0(8'h05, 32'h0BADF00D, 4'hF); csb1 = 1'b0; addr1 = 8'h05;
        step();
        idle();
        rstb = 1'b1;
        step();
        chk("midrst_no_vld_b", 32'(vld0_b), 32'd0);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h05;
        step();
        idle();
        step();
        chk("retained_b_dout0", dout0_b, 32'h55555555);

        // Streaming reads of 0..15 on port 1.
        vld_count = 0;
        for (int i = 0; i < 16; i++) begin
            csb1 = 1'b0; addr1 = 8'(i);
            step();
            vld_count += int'(vld1_a);
        end
        csb1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vld_count += int'(vld1_a);
        end
        chk("stream_vld_count", 32'(vld_count), 32'd16);
        chk("stream_hold_b", dout1_b, m_mem[15]);

`ifdef SRAM_COLLISION_CHECK_EN
        // Drive enough collisions to saturate the counter.
        for (int i = 0; i < 300; i++) begin
            wr0(8'h07, $urandom, 4'(i)); csb1 = 1'b0; addr1 = 8'h07;
            step();
        end
        idle();
        step();
        chk("sat_cnt_a", 32'(cnt_a), 32'd255);
        chk("sat_cnt_b", 32'(cnt_b), 32'd255);
`endif

        // Random traffic on a small address window, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            csb0   = 1'($urandom_range(0, 2) == 0);
            web0   = 1'($urandom);
            addr0  = 8'($urandom_range(0, 15));
            din0   = $urandom;
            wmask0 = 4'($urandom);
            csb1   = 1'($urandom_range(0, 2) == 0);
            addr1  = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) begin
                rstb = 1'b0;
                #1;
                model_reset();
                check_all();
                step();
                rstb = 1'b1;
            end else begin
                step();
            end
        end
        idle();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
